// File: rtl/pc_unit.sv
// pc_unit: registered program counter with a circular return-address stack.
// Optional build macro: PC_WRAP_TRAP_EN (redirect to TRAP_PC when the
// sequential or relative next-PC wraps; otherwise plain modulo wrap).
//
// Ports:
//   clk_i         rising-edge clock
//   rst_i         synchronous active-high reset
//   stall_i       hold PC and RAS; all other controls ignored
//   jmx_i         relative jump: next = pc + sext(imm)
//   bmx_i         indirect jump: next = rb
//   imm_i         signed jump offset
//   rb_i          indirect jump target
//   call_i        push pc+1 onto the RAS alongside the selected redirect
//   ret_i         pop RAS top as next PC
//   pc_o          current PC
//   ras_count_o   number of valid RAS entries
//   ras_ovf_o     sticky: push while full
//   ras_unf_o     sticky: ret while empty
//   wrap_trap_o   one-cycle pulse on a trapped wrap (0 without the macro)
module pc_unit #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned      RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] TRAP_PC   = WIDTH'(8'hF0)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         stall_i,
    input  logic                         jmx_i,
    input  logic                         bmx_i,
    input  logic [WIDTH-1:0]             imm_i,
    input  logic [WIDTH-1:0]             rb_i,
    input  logic                         call_i,
    input  logic                         ret_i,
    output logic [WIDTH-1:0]             pc_o,
    output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
    output logic                         ras_ovf_o,
    output logic                         ras_unf_o,
    output logic                         wrap_trap_o
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             trap_d;

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic             ras_we;
    logic [PTR_W-1:0] ras_waddr;

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_rel;
    logic             ras_empty;
    logic             ras_full;

    assign pc_inc    = pc_q + WIDTH'(1);
    assign pc_rel    = pc_q + imm_i;
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

`ifdef PC_WRAP_TRAP_EN
    // Relative target computed two bits wider so any carry/borrow out of
    // the unsigned PC range shows up in the top bits.
    logic [WIDTH+1:0] rel_ext;
    logic             wrap_hit;
    assign rel_ext  = {2'b00, pc_q} + {{2{imm_i[WIDTH-1]}}, imm_i};
    assign wrap_hit = jmx_i ? (rel_ext[WIDTH+1:WIDTH] != 2'b00) : (pc_q == '1);
`else
    logic unused_trap_pc;
    assign unused_trap_pc = ^TRAP_PC;
`endif

    // Next-state selection for PC and RAS bookkeeping.
    always_comb begin
        pc_d      = pc_q;
        top_d     = top_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        trap_d    = 1'b0;
        ras_we    = 1'b0;
        ras_waddr = top_q + PTR_W'(1);

        if (!stall_i) begin
            if (ret_i && !ras_empty) begin
                pc_d = ras_q[top_q];
                if (call_i) begin
                    // Pop and push cancel: reuse the popped slot in place.
                    ras_we    = 1'b1;
                    ras_waddr = top_q;
                end else begin
                    top_d = top_q - PTR_W'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else begin
                if (ret_i) begin
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end else if (bmx_i) begin
                    pc_d = rb_i;
                end else if (jmx_i) begin
                    pc_d = pc_rel;
                end else begin
                    pc_d = pc_inc;
                end
`ifdef PC_WRAP_TRAP_EN
                if (!ret_i && !bmx_i && wrap_hit) begin
                    pc_d   = TRAP_PC;
                    trap_d = 1'b1;
                end
`endif
                // Push advances top; when full it lands on the oldest entry.
                if (call_i) begin
                    ras_we = 1'b1;
                    top_d  = top_q + PTR_W'(1);
                    if (ras_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q  <= RESET_PC;
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // RAS storage; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && ras_we) begin
            ras_q[ras_waddr] <= pc_inc;
        end
    end

`ifdef PC_WRAP_TRAP_EN
    logic trap_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end
    assign wrap_trap_o = trap_q;
`else
    logic unused_trap_d;
    assign unused_trap_d = trap_d;
    assign wrap_trap_o   = 1'b0;
`endif

    assign pc_o        = pc_q;
    assign ras_count_o = cnt_q;
    assign ras_ovf_o   = ovf_q;
    assign ras_unf_o   = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic       clk = 1'b0;
    logic       rst, stall, jmx, bmx, call, ret;
    logic [7:0] imm, rb;
    logic [7:0] pc;
    logic [2:0] ras_count;
    logic       ras_ovf, ras_unf, wrap_trap;

    int checks = 0;
    int errors = 0;

    pc_unit dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .stall_i    (stall),
        .jmx_i      (jmx),
        .bmx_i      (bmx),
        .imm_i      (imm),
        .rb_i       (rb),
        .call_i     (call),
        .ret_i      (ret),
        .pc_o       (pc),
        .ras_count_o(ras_count),
        .ras_ovf_o  (ras_ovf),
        .ras_unf_o  (ras_unf),
        .wrap_trap_o(wrap_trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_ctl();
        stall = 0; jmx = 0; bmx = 0; call = 0; ret = 0; imm = 8'd0; rb = 8'd0;
    endtask

    // Apply current controls for one edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        idle_ctl();
    endtask

    task automatic set_pc(input logic [7:0] v);
        bmx = 1; rb = v; tick();
    endtask

    task automatic check_pc_cnt(input string tag, input logic [7:0] p, input logic [2:0] c);
        check({tag, "_pc"}, 32'(pc), 32'(p));
        check({tag, "_cnt"}, 32'(ras_count), 32'(c));
    endtask

    initial begin
        rst = 1; idle_ctl();
        @(negedge clk);
        tick();
        rst = 0;
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_cnt", 32'(ras_count), 32'd0);
        check("rst_ovf", 32'(ras_ovf), 32'd0);
        check("rst_unf", 32'(ras_unf), 32'd0);
        check("rst_trap", 32'(wrap_trap), 32'd0);

        // Sequential, relative and indirect.
        set_pc(8'd120);                 check("set120", 32'(pc), 32'd120);
        tick();                         check("idle121", 32'(pc), 32'd121);
        jmx = 1; imm = 8'd6; tick();    check("jmx127", 32'(pc), 32'd127);
        jmx = 1; imm = 8'd6; tick();    check("jmx133", 32'(pc), 32'd133);
        bmx = 1; rb = 8'd55; tick();    check("bmx55", 32'(pc), 32'd55);
        set_pc(8'd90);
        bmx = 1; jmx = 1; rb = 8'd55; imm = 8'd6; tick();
        check("bmx_wins", 32'(pc), 32'd55);

        // Wrap behaviour.
        set_pc(8'd0);
        jmx = 1; imm = 8'hFC; tick();
`ifdef PC_WRAP_TRAP_EN
        check("neg_wrap_pc", 32'(pc), 32'hF0);
        check("neg_wrap_trap", 32'(wrap_trap), 32'd1);
        tick();
        check("trap_pulse_end", 32'(wrap_trap), 32'd0);
        check("after_trap_pc", 32'(pc), 32'hF1);
`else
        check("neg_wrap_pc", 32'(pc), 32'd252);
        check("neg_wrap_trap", 32'(wrap_trap), 32'd0);
        tick();
        check("after_wrap_pc", 32'(pc), 32'd253);
`endif
        set_pc(8'd255);
        tick();
`ifdef PC_WRAP_TRAP_EN
        check("inc_wrap_pc", 32'(pc), 32'hF0);
        check("inc_wrap_trap", 32'(wrap_trap), 32'd1);
`else
        check("inc_wrap_pc", 32'(pc), 32'd0);
`endif
        set_pc(8'd250);
        jmx = 1; imm = 8'd10; tick();
`ifdef PC_WRAP_TRAP_EN
        check("pos_wrap_pc", 32'(pc), 32'hF0);
`else
        check("pos_wrap_pc", 32'(pc), 32'd4);
`endif
        check("bmx_no_trap_pre", 32'(ras_count), 32'd0);
        set_pc(8'd3);
        check("bmx_no_trap", 32'(wrap_trap), 32'd0);

        // Call / return with stall.
        set_pc(8'd10);
        call = 1; bmx = 1; rb = 8'd40; tick();
        check_pc_cnt("call40", 8'd40, 3'd1);
        for (int i = 0; i < 3; i++) begin
            stall = 1; ret = 1; call = 1; jmx = 1; imm = 8'd9; tick();
            check_pc_cnt("stall", 8'd40, 3'd1);
        end
        ret = 1; tick();
        check_pc_cnt("ret11", 8'd11, 3'd0);
        check("ret11_unf", 32'(ras_unf), 32'd0);

        // Overflow: pushes 2..6, depth 4 keeps 3..6.
        for (int i = 1; i <= 5; i++) begin
            set_pc(8'(i));
            call = 1; jmx = 1; imm = 8'd0; tick();
            check("ovf_pc", 32'(pc), 32'(i));
            check("ovf_cnt", 32'(ras_count), (i < 4) ? 32'(i) : 32'd4);
            check("ovf_flag", 32'(ras_ovf), (i == 5) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            ret = 1; tick();
            check_pc_cnt("pop", 8'(6 - i), 3'(3 - i));
        end
        check("pop_unf0", 32'(ras_unf), 32'd0);
        ret = 1; tick();
        check_pc_cnt("unf_ret", 8'd4, 3'd0);
        check("unf_flag", 32'(ras_unf), 32'd1);
        check("ovf_sticky", 32'(ras_ovf), 32'd1);

        // call+ret: empty then non-empty.
        call = 1; ret = 1; tick();
        check_pc_cnt("cr_empty", 8'd5, 3'd1);
        call = 1; ret = 1; tick();
        check_pc_cnt("cr_full", 8'd5, 3'd1);
        ret = 1; tick();
        check_pc_cnt("cr_pop", 8'd6, 3'd0);

        // Reset mid-operation.
        call = 1; tick();
        check_pc_cnt("pre_rst", 8'd7, 3'd1);
        rst = 1; call = 1; ret = 1; tick();
        rst = 0;
        check_pc_cnt("midrst", 8'd0, 3'd0);
        check("midrst_ovf", 32'(ras_ovf), 32'd0);
        check("midrst_unf", 32'(ras_unf), 32'd0);
        ret = 1; tick();
        check_pc_cnt("midrst_nopush", 8'd1, 3'd0);
        check("midrst_unf2", 32'(ras_unf), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
